shift_register_universal: RTL and testbench
===========================================

# shift_register_universal

Parametrised universal shift register: the next generation of the fixed 4/8-bit PIPO register. It provides parallel load, hold, logical/arithmetic shifts and rotates in both directions, with serial inputs and outputs at both ends. A burst engine performs an N-step shift autonomously under a start/busy/done handshake. It serves as the general-purpose storage and serialisation element in the datapath.

## Interface
- WIDTH, 8: register width in bits (>= 2).
- AMT_W, 4: width of the burst step-count input.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- mode  in  3  operation select: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 HOLD.
- d  in  WIDTH  parallel load data.
- ser_in_lsb  in  1  bit entering bit 1 on SHL.
- ser_in_msb  in  1  bit entering bit WIDTH on SHR.
- start  in  1  burst request; sampled only while idle.
- amount  in  AMT_W  burst step count.
- outputs  out  WIDTH  register contents; bit WIDTH is the MSB.
- ser_out_msb  out  1  equals outputs[WIDTH] (combinational).
- ser_out_lsb  out  1  equals outputs[1] (combinational).
- busy  out  1  burst in progress.
- done  out  1  single-cycle pulse at the end of a burst.

## Operation
- Step functions, one step per edge:
  - SHL: outputs moves toward the MSB; ser_in_lsb enters bit 1; bit WIDTH is discarded.
  - SHR: outputs moves toward the LSB; ser_in_msb enters bit WIDTH.
  - ROL: bit WIDTH wraps to bit 1.
  - ROR: bit 1 wraps to bit WIDTH.
  - ASR: shifts right; bit WIDTH is replicated.
  - LOAD: outputs <= d.
  - HOLD and mode 7: no change.
- FSM states are IDLE and BUSY.
- IDLE, start=0: the current mode is applied every edge. This is single-step operation.
- IDLE, start=1, mode in {SHL, SHR, ROL, ROR, ASR}:
  - Mode is latched; amount is latched into a remaining counter. There is no shift on the acceptance edge.
  - amount != 0: go to BUSY.
  - amount == 0: stay in IDLE and pulse done on the next cycle.
- IDLE, start=1, mode in {HOLD, LOAD, 7}: start is ignored and the mode is applied normally.
- BUSY:
  - Each edge applies one step of the latched mode and decrements remaining.
  - Serial inputs are sampled live every step.
  - mode, d, start and amount are ignored.
  - On the edge where remaining goes 1 -> 0: return to IDLE and assert done for exactly one cycle.
- Amount larger than WIDTH is legal; steps are performed literally with no modulo reduction.
- Reset outputs: outputs=0, busy=0, done=0, state=IDLE, remaining=0. ser_out_* are therefore 0.
- Reset asserted mid-burst aborts the burst immediately with no done pulse. The latched mode is discarded.

## Timing
- Single-step/LOAD latency: result is visible 1 cycle after the edge on which mode is sampled.
- Burst with amount=N>0, start accepted at edge k:
  - Steps occur at edges k+1 through k+N.
  - busy is high from after edge k to after edge k+N (N cycles).
  - done is high from edge k+N to edge k+N+1.
- Burst with amount=0: done is high for the cycle after edge k; busy stays 0.
- A new start is accepted on the cycle done is high (back-to-back bursts allowed), since the FSM is already IDLE.
- busy and done are registered; they never depend combinationally on inputs.

## Structure
- Shared package `shift_pkg`:
  - 3-bit mode constants (HOLD, LOAD, SHL, SHR, ROL, ROR, ASR).
  - FSM state constants.
- Sub-module `shift_step`: combinational next-value function (mode, current value, ser_in_lsb, ser_in_msb) -> next value. It is used by both the single-step and burst paths.
- The top level holds the register, the FSM, the remaining counter and the latched mode.

## Test plan
- Reset: assert reset mid-cycle (asynchronous) -> outputs=0x00, busy=0, done=0 immediately. Release, then HOLD for 3 cycles -> still 0x00.
- LOAD d=0xA5 -> outputs=0xA5 next cycle, ser_out_msb=1, ser_out_lsb=1. HOLD -> stays 0xA5.
- From 0x81, each checked after a single step:
  - SHL with ser_in_lsb=1 -> 0x03.
  - SHR with ser_in_msb=0 -> 0x40.
  - ASR -> 0xC0.
  - ROR -> 0xC0.
- Burst ROL, amount=3, from 0x81:
  - busy high for 3 cycles, then done pulses for 1 cycle, final value 0x0C.
  - Toggle mode and d throughout the burst -> no effect on the result.
- Edge counts:
  - amount=0 -> done pulses 1 cycle after acceptance, busy never high, value unchanged.
  - ROL amount=9 from 0x81 -> final value 0x03 after 9 busy cycles.
  - Issue a second start during the done cycle -> accepted.
- Reset at the 2nd step of a 5-step SHL burst -> outputs=0x00, busy=0, no done pulse. The next start is accepted normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared mode and state encodings for the universal shift register.
package shift_pkg;

   typedef enum logic [2:0] {
      M_HOLD  = 3'd0,
      M_LOAD  = 3'd1,
      M_SHL   = 3'd2,
      M_SHR   = 3'd3,
      M_ROL   = 3'd4,
      M_ROR   = 3'd5,
      M_ASR   = 3'd6,
      M_HOLD7 = 3'd7
   } mode_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   // Only the shift/rotate modes may be run as a burst.
   function automatic logic is_burst_mode(input mode_t m);
      return (m == M_SHL) || (m == M_SHR) || (m == M_ROL) ||
             (m == M_ROR) || (m == M_ASR);
   endfunction

endpackage

// File: rtl/shift_step.sv
// One-step next-value function shared by the single-step and burst paths.
// LOAD and HOLD pass the value through; the top level handles LOAD data.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  mode_t             mode,
   input  logic [WIDTH-1:0]  value,
   input  logic              ser_in_lsb,
   input  logic              ser_in_msb,
   output logic [WIDTH-1:0]  next_value
);

   // Select the shifted/rotated form of the current value.
   always_comb begin
      next_value = value;
      case (mode)
         M_SHL:   next_value = {value[WIDTH-2:0], ser_in_lsb};
         M_SHR:   next_value = {ser_in_msb, value[WIDTH-1:1]};
         M_ROL:   next_value = {value[WIDTH-2:0], value[WIDTH-1]};
         M_ROR:   next_value = {value[0], value[WIDTH-1:1]};
         M_ASR:   next_value = {value[WIDTH-1], value[WIDTH-1:1]};
         default: next_value = value;
      endcase
   end

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register with single-step operation and an N-step burst
// engine under a start/busy/done handshake.
//
// state  | meaning
// S_IDLE | live mode applied every edge; a start with a shift mode is accepted
// S_BUSY | latched mode applied every edge until remaining reaches zero
module shift_register_universal
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        mode,
   input  logic [WIDTH-1:0]  d,
   input  logic              ser_in_lsb,
   input  logic              ser_in_msb,
   input  logic              start,
   input  logic [AMT_W-1:0]  amount,
   output logic [WIDTH-1:0]  outputs,
   output logic              ser_out_msb,
   output logic              ser_out_lsb,
   output logic              busy,
   output logic              done
);

   state_t             state, state_next;
   mode_t              lat_mode, lat_mode_next;
   mode_t              live_mode, step_mode;
   logic [AMT_W-1:0]   remaining, remaining_next;
   logic [WIDTH-1:0]   value_next, step_value;
   logic               done_next;

   assign live_mode = mode_t'(mode);
   assign step_mode = (state == S_BUSY) ? lat_mode : live_mode;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .mode       (step_mode),
      .value      (outputs),
      .ser_in_lsb (ser_in_lsb),
      .ser_in_msb (ser_in_msb),
      .next_value (step_value)
   );

   // State, counter, latched mode, data and done registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         lat_mode  <= M_HOLD;
         remaining <= '0;
         outputs   <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_next;
         lat_mode  <= lat_mode_next;
         remaining <= remaining_next;
         outputs   <= value_next;
         done      <= done_next;
      end
   end

   // Next-state, burst bookkeeping and data-path selection.
   always_comb begin
      state_next     = state;
      lat_mode_next  = lat_mode;
      remaining_next = remaining;
      value_next     = outputs;
      done_next      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && is_burst_mode(live_mode)) begin
               // Acceptance edge: latch only, no shift yet.
               lat_mode_next  = live_mode;
               remaining_next = amount;
               if (amount != '0) state_next = S_BUSY;
               else              done_next  = 1'b1;
            end else if (live_mode == M_LOAD) begin
               value_next = d;
            end else begin
               value_next = step_value;
            end
         end
         S_BUSY: begin
            value_next     = step_value;
            remaining_next = remaining - 1'b1;
            if (remaining == AMT_W'(1)) begin
               state_next = S_IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign busy        = (state == S_BUSY);
   assign ser_out_msb = outputs[WIDTH-1];
   assign ser_out_lsb = outputs[0];

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench for shift_register_universal (WIDTH=8, AMT_W=4).
module tb_shift_register_universal;

   localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                          ROL = 3'd4, ROR = 3'd5, ASR = 3'd6, HOLD7 = 3'd7;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] mode = HOLD;
   logic [7:0] d = '0;
   logic       ser_in_lsb = 1'b0, ser_in_msb = 1'b0;
   logic       start = 1'b0;
   logic [3:0] amount = '0;
   logic [7:0] outputs;
   logic       ser_out_msb, ser_out_lsb, busy, done;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   shift_register_universal #(.WIDTH(8), .AMT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .mode        (mode),
      .d           (d),
      .ser_in_lsb  (ser_in_lsb),
      .ser_in_msb  (ser_in_msb),
      .start       (start),
      .amount      (amount),
      .outputs     (outputs),
      .ser_out_msb (ser_out_msb),
      .ser_out_lsb (ser_out_lsb),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] init;
      logic [2:0] mode;
      logic       sil;
      logic       sim;
      logic [7:0] expv;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic push_exp(input logic [7:0] v);
      exp_q.push_back(v);
   endtask

   task automatic pop_chk(input string name);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, got 0x%0h", name, outputs);
      end else begin
         e = exp_q.pop_front();
         chk(name, outputs, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load a value, then run one burst and check busy/done/result timing.
   task automatic run_burst(input string name, input logic [2:0] bm, input logic [3:0] n,
                            input logic [7:0] init, input logic [7:0] expv, input bit toggle);
      mode = LOAD; d = init; start = 1'b0;
      push_exp(init);
      tick();
      pop_chk({name, "_load"});
      mode = bm; amount = n; start = 1'b1;
      tick();
      start = 1'b0;
      if (n == 0) begin
         chk({name, "_z_busy"}, busy, 0);
         chk({name, "_z_done"}, done, 1);
         chk({name, "_z_val"}, outputs, init);
      end else begin
         chk({name, "_acc_busy"}, busy, 1);
         chk({name, "_acc_val"}, outputs, init);
         for (int j = 1; j <= n; j++) begin
            if (toggle) begin
               mode = 3'($urandom_range(0, 7));
               d = 8'($urandom);
               start = 1'($urandom);
               amount = 4'($urandom);
            end
            tick();
            if (j < n) begin
               checks++;
               if (!(busy === 1'b1 && done === 1'b0)) begin
                  errors++;
                  $display("FAIL %s_step%0d: busy=%0b done=%0b expected busy=1 done=0",
                           name, j, busy, done);
               end
            end
         end
         start = 1'b0;
         chk({name, "_end_busy"}, busy, 0);
         chk({name, "_end_done"}, done, 1);
         chk({name, "_end_val"}, outputs, expv);
      end
      mode = HOLD; start = 1'b0;
      tick();
      chk({name, "_done_clr"}, done, 0);
      chk({name, "_hold_val"}, outputs, expv);
   endtask

   initial begin
      vecs[0]  = '{"load_a5", 8'hA5, HOLD,  1'b0, 1'b0, 8'hA5};
      vecs[1]  = '{"shl_si1", 8'h81, SHL,   1'b1, 1'b0, 8'h03};
      vecs[2]  = '{"shr_si0", 8'h81, SHR,   1'b0, 1'b0, 8'h40};
      vecs[3]  = '{"asr_81",  8'h81, ASR,   1'b0, 1'b0, 8'hC0};
      vecs[4]  = '{"ror_81",  8'h81, ROR,   1'b0, 1'b0, 8'hC0};
      vecs[5]  = '{"shr_si1", 8'h3C, SHR,   1'b0, 1'b1, 8'h9E};
      vecs[6]  = '{"shl_si0", 8'h3C, SHL,   1'b0, 1'b0, 8'h78};
      vecs[7]  = '{"asr_7e",  8'h7E, ASR,   1'b0, 1'b1, 8'h3F};
      vecs[8]  = '{"mode7",   8'h81, HOLD7, 1'b1, 1'b1, 8'h81};
      vecs[9]  = '{"rol_80",  8'h80, ROL,   1'b0, 1'b0, 8'h01};
      vecs[10] = '{"ror_01",  8'h01, ROR,   1'b0, 1'b0, 8'h80};
      vecs[11] = '{"shl_out", 8'h80, SHL,   1'b0, 1'b0, 8'h00};

      // Power-on reset, then an asynchronous reset mid-cycle.
      tick();
      reset = 1'b0;
      mode = LOAD; d = 8'hFF;
      tick();
      chk("pre_reset_load", outputs, 8'hFF);
      mode = HOLD;
      #3 reset = 1'b1;
      #1;
      chk("async_rst_out", outputs, 8'h00);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      chk("async_rst_ser", {ser_out_msb, ser_out_lsb}, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push_exp(8'h00);
         tick();
         pop_chk("hold_after_rst");
      end

      // LOAD 0xA5 with serial-out checks, then HOLD.
      mode = LOAD; d = 8'hA5;
      push_exp(8'hA5);
      tick();
      pop_chk("load_a5");
      chk("ser_out_msb_a5", ser_out_msb, 1);
      chk("ser_out_lsb_a5", ser_out_lsb, 1);
      mode = HOLD;
      push_exp(8'hA5);
      tick();
      pop_chk("hold_a5");

      // Table-driven single steps.
      foreach (vecs[i]) begin
         mode = LOAD; d = vecs[i].init;
         push_exp(vecs[i].init);
         tick();
         pop_chk({vecs[i].name, "_init"});
         mode = vecs[i].mode; ser_in_lsb = vecs[i].sil; ser_in_msb = vecs[i].sim;
         d = ~vecs[i].init;
         push_exp(vecs[i].expv);
         tick();
         pop_chk(vecs[i].name);
      end
      mode = HOLD; ser_in_lsb = 1'b0; ser_in_msb = 1'b0;

      // Start with a non-shift mode is ignored; LOAD applies normally.
      mode = LOAD; d = 8'h5A; start = 1'b1; amount = 4'd3;
      tick();
      start = 1'b0; mode = HOLD;
      chk("start_load_val", outputs, 8'h5A);
      chk("start_load_busy", busy, 0);
      tick();
      chk("start_load_done", done, 0);

      // Bursts.
      run_burst("rol3", ROL, 4'd3, 8'h81, 8'h0C, 1'b0);
      run_burst("rol3_tog", ROL, 4'd3, 8'h81, 8'h0C, 1'b1);
      run_burst("amt0", ROL, 4'd0, 8'h81, 8'h81, 1'b0);
      run_burst("rol9", ROL, 4'd9, 8'h81, 8'h03, 1'b0);
      ser_in_msb = 1'b1;
      run_burst("shr4_si1", SHR, 4'd4, 8'h00, 8'hF0, 1'b0);
      ser_in_msb = 1'b0;

      // Back-to-back: second start issued during the done cycle.
      mode = LOAD; d = 8'h81;
      tick();
      mode = ROL; amount = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("b2b_first_done", done, 1);
      chk("b2b_first_val", outputs, 8'h0C);
      mode = ROR; amount = 4'd2; start = 1'b1;
      tick();
      start = 1'b0; mode = HOLD;
      chk("b2b_accept_busy", busy, 1);
      chk("b2b_accept_done", done, 0);
      tick(); tick();
      chk("b2b_second_done", done, 1);
      chk("b2b_second_val", outputs, 8'h03);
      tick();

      // Reset during the 2nd step of a 5-step SHL burst.
      mode = LOAD; d = 8'h81;
      tick();
      ser_in_lsb = 1'b0;
      mode = SHL; amount = 4'd5; start = 1'b1;
      tick();
      start = 1'b0; mode = HOLD;
      tick();
      chk("abort_step1_val", outputs, 8'h02);
      #2 reset = 1'b1;
      #1;
      chk("abort_rst_val", outputs, 8'h00);
      chk("abort_rst_busy", busy, 0);
      @(negedge clk);
      reset = 1'b0;
      begin
         int done_seen;
         done_seen = 0;
         for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
         end
         chk("abort_no_done", done_seen, 0);
         chk("abort_hold_val", outputs, 8'h00);
      end
      run_burst("post_abort", ROL, 4'd3, 8'h81, 8'h0C, 1'b0);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
